// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Arbitrates the L1 instruction cache (read-only) and the L1 data cache
//   (fill and writeback) onto a single shared L2 port. One transaction is
//   outstanding at a time; simultaneous requests are resolved round-robin.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   i_read, i_address          L1I miss request (held until i_resp)
//   i_rdata, i_resp            line and one-cycle completion pulse to L1I
//   d_read, d_write            L1D fill / writeback request (held until d_resp)
//   d_address, d_wdata         L1D request payload
//   d_rdata, d_resp            line and one-cycle completion pulse to L1D
//   mem_read, mem_write        request strobes to L2
//   mem_address, mem_wdata     latched request payload to L2
//   mem_rdata, mem_resp        L2 returned line and completion
//   busy                       high while a transaction is outstanding
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    i_pend;
    logic                    d_pend;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // State and request-latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;   // D wins the first tie after reset
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state and grant-time latching
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                // I wins when alone, or on a tie when D was served last
                if (i_pend && (!d_pend || (last_grant_q == GRANT_D))) begin
                    state_d    = SERVE_I;
                    op_write_d = 1'b0;
                    addr_d     = i_address;
                    wdata_d    = '0;
                end else if (d_pend) begin
                    state_d    = SERVE_D;
                    // read+write together is treated as a writeback
                    op_write_d = d_write;
                    addr_d     = d_address;
                    wdata_d    = d_wdata;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; held low while reset is asserted so an abandoned
    // transaction can neither strobe L2 nor complete to a requester.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            case (state_q)
                SERVE_I: begin
                    mem_read = ~op_write_q;
                    i_resp   = mem_resp;
                    busy     = 1'b1;
                end
                SERVE_D: begin
                    mem_read  = ~op_write_q;
                    mem_write = op_write_q;
                    d_resp    = mem_resp;
                    busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    localparam logic [LW-1:0] PAT_A5  = {32{8'hA5}};
    localparam logic [LW-1:0] PAT_I   = {8{32'h1234_5678}};
    localparam logic [LW-1:0] PAT_D   = {8{32'hCAFE_F00D}};

    initial begin
        reset     = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;

        // ---- reset state ----
        step();
        step();
        chk("rst_busy",   busy,        0);
        chk("rst_mrd",    mem_read,    0);
        chk("rst_mwr",    mem_write,   0);
        chk("rst_addr",   mem_address, 0);
        chk("rst_wdata",  mem_wdata,   0);
        reset = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);

        // ---- single I read ----
        i_read    = 1'b1;
        i_address = 32'h0000_0040;
        step();
        chk("i1_mrd",  mem_read,    1);
        chk("i1_mwr",  mem_write,   0);
        chk("i1_addr", mem_address, 32'h40);
        chk("i1_busy", busy,        1);
        chk("i1_noresp", i_resp,    0);
        step();
        chk("i1_wait2", i_resp, 0);
        step();
        chk("i1_wait3", i_resp, 0);
        mem_resp  = 1'b1;
        mem_rdata = PAT_I;
        #1;
        chk("i1_resp",  i_resp,  1);
        chk("i1_dresp", d_resp,  0);
        chk("i1_rdata", i_rdata, PAT_I);
        i_read = 1'b0;
        step();
        mem_resp = 1'b0;
        #1;
        chk("i1_idle_busy", busy,     0);
        chk("i1_idle_mrd",  mem_read, 0);

        // ---- tie after reset, then continuous contention ----
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_read    = 1'b1;
        d_address = 32'h0000_0200;
        step();
        for (int k = 0; k < 6; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            chk($sformatf("rr%0d_addr", k), mem_address, exp_d ? 32'h200 : 32'h100);
            chk($sformatf("rr%0d_mrd", k),  mem_read, 1);
            mem_resp  = 1'b1;
            mem_rdata = exp_d ? PAT_D : PAT_I;
            #1;
            chk($sformatf("rr%0d_dresp", k), d_resp, exp_d);
            chk($sformatf("rr%0d_iresp", k), i_resp, !exp_d);
            step();
            mem_resp = 1'b0;
            #1;
            chk($sformatf("rr%0d_gap", k), busy, 0);
            step();
        end
        i_read = 1'b0;
        d_read = 1'b0;
        // a last grant (D) was taken in the final loop step; finish it
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;

        // ---- writeback with wdata changing after grant ----
        do_reset();
        d_write   = 1'b1;
        d_address = 32'h8000_0100;
        d_wdata   = PAT_A5;
        step();
        d_wdata = '0;
        #1;
        chk("wb_mwr",   mem_write,   1);
        chk("wb_mrd",   mem_read,    0);
        chk("wb_addr",  mem_address, 32'h8000_0100);
        chk("wb_wdata", mem_wdata,   PAT_A5);
        step();
        chk("wb_wdata2", mem_wdata, PAT_A5);
        chk("wb_mwr2",   mem_write, 1);
        mem_resp = 1'b1;
        #1;
        chk("wb_dresp", d_resp, 1);
        chk("wb_iresp", i_resp, 0);
        d_write = 1'b0;
        step();
        mem_resp = 1'b0;
        #1;
        chk("wb_idle", busy, 0);

        // ---- read+write together is a write ----
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_0300;
        d_wdata   = PAT_D;
        step();
        chk("rw_mwr",   mem_write, 1);
        chk("rw_mrd",   mem_read,  0);
        chk("rw_wdata", mem_wdata, PAT_D);
        mem_resp = 1'b1;
        d_read   = 1'b0;
        d_write  = 1'b0;
        step();
        mem_resp = 1'b0;
        #1;
        chk("rw_idle", busy, 0);

        // ---- reset mid-transaction ----
        i_read    = 1'b1;
        i_address = 32'h0000_0080;
        step();
        chk("mr_busy", busy, 1);
        reset  = 1'b1;
        i_read = 1'b0;
        #1;
        chk("mr_in_rst_mrd",  mem_read, 0);
        chk("mr_in_rst_busy", busy,     0);
        step();
        reset    = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("mr_iresp", i_resp,   0);
        chk("mr_busy2", busy,     0);
        chk("mr_mrd",   mem_read, 0);
        step();
        chk("mr_still_idle", busy, 0);
        mem_resp = 1'b0;

        // ---- stray mem_resp in IDLE ----
        step();
        mem_resp = 1'b1;
        #1;
        chk("stray_iresp", i_resp, 0);
        chk("stray_dresp", d_resp, 0);
        step();
        chk("stray_busy", busy, 0);
        mem_resp = 1'b0;
        step();
        chk("stray_busy2", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
